// File: rtl/aes_pkg.sv
// aes_pkg: shared types and round-count constants for the AES round sequencer
package aes_pkg;
  typedef enum logic [1:0] {IDLE, INIT, ROUND, DONE} seq_state_t;
  localparam int AES128_ROUNDS = 10;
  localparam int AES192_ROUNDS = 12;
  localparam int AES256_ROUNDS = 14;
  localparam int RK_IDX_W = 4;
endpackage

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: steps the shared AES round datapath through one block and holds the result
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES128_ROUNDS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                key_busy,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                decrypt,
  output logic                load_state,
  output logic                round_en,
  output logic                final_round,
  output logic                inv,
  output logic [RK_IDX_W-1:0] rk_idx,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic [15:0]         blk_cnt
);
  localparam logic [RK_IDX_W-1:0] NR = RK_IDX_W'(NUM_ROUNDS);
  seq_state_t          state_q;
  logic [RK_IDX_W-1:0] rnd_q;
  logic                mode_q;
  logic [15:0]         cnt_q;
  logic                last, out_hs, in_hs;
  assign last   = rnd_q == NR;
  assign out_hs = state_q == DONE && out_ready;
  // accept from IDLE, or from DONE only when the held result leaves in the same cycle
  assign in_ready = !rst && !flush && !key_busy && (state_q == IDLE || out_hs);
  assign in_hs    = in_valid && in_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (flush) begin
      state_q <= IDLE;
      rnd_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_hs) begin
          mode_q  <= decrypt;
          state_q <= INIT;
        end
        INIT: begin
          rnd_q   <= RK_IDX_W'(1);
          state_q <= ROUND;
        end
        ROUND: if (last) state_q <= DONE;
               else rnd_q <= rnd_q + 1'b1;
        DONE: if (out_ready) begin
          cnt_q <= cnt_q + 16'd1;
          if (in_hs) begin
            mode_q  <= decrypt;
            state_q <= INIT;
          end else state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  always_comb begin
    busy        = !rst && state_q != IDLE;
    load_state  = !rst && state_q == INIT;
    round_en    = !rst && state_q == ROUND;
    final_round = round_en && last;
    out_valid   = !rst && state_q == DONE;
    inv         = !rst && mode_q;
    blk_cnt     = rst ? '0 : cnt_q;
    rk_idx      = load_state ? (mode_q ? NR : '0) :
                  round_en   ? (mode_q ? NR - rnd_q : rnd_q) : '0;
  end
endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: timeline reference model of one block's schedule, directed plus random stimulus
module tb_aes_round_sequencer;
  localparam int NR = 10;
  logic clk = 0, rst = 1, flush = 0, key_busy = 0, in_valid = 0, decrypt = 0, out_ready = 0;
  logic in_ready, load_state, round_en, final_round, inv, out_valid, busy;
  logic [3:0] rk_idx;
  logic [15:0] blk_cnt;
  int checks = 0, failures = 0;
  // model: whether a block is in flight, cycles since its acceptance, its direction, completions
  bit act = 0, m = 0;
  int ph = 0;
  logic [15:0] cnt = 0;

  aes_round_sequencer #(.NUM_ROUNDS(NR)) dut (
    .clk(clk), .rst(rst), .flush(flush), .key_busy(key_busy), .in_valid(in_valid),
    .in_ready(in_ready), .decrypt(decrypt), .load_state(load_state), .round_en(round_en),
    .final_round(final_round), .inv(inv), .rk_idx(rk_idx), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .blk_cnt(blk_cnt)
  );

  always #5 clk = ~clk;

  task automatic step(input string tag, input bit r, fl, kb, iv, dec, ordy);
    bit ir, ld, re, fr, ov, hs;
    int rk;
    logic [10:0] e, o;
    logic [15:0] ec;
    @(negedge clk);
    rst = r; flush = fl; key_busy = kb; in_valid = iv; decrypt = dec; out_ready = ordy;
    #1;
    {ir, ld, re, fr, ov} = '0;
    rk = 0;
    if (!act) ir = !fl && !kb;
    else if (ph == 1) begin ld = 1; rk = m ? NR : 0; end
    else if (ph <= NR + 1) begin re = 1; rk = m ? NR - (ph - 1) : ph - 1; fr = ph == NR + 1; end
    else begin ov = 1; ir = ordy && !kb && !fl; end
    e = r ? '0 : {ir, ld, re, fr, m, 4'(rk), ov, act};
    ec = r ? '0 : cnt;
    o = {in_ready, load_state, round_en, final_round, inv, rk_idx, out_valid, busy};
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s ctl {ir,ld,re,fr,inv,rk,ov,busy} got=%b exp=%b ph=%0d", tag, o, e, ph);
    end
    checks++;
    assert (blk_cnt === ec) else begin
      failures++;
      $error("FAIL %s blk_cnt got=%h exp=%h", tag, blk_cnt, ec);
    end
    hs = iv && ir && !r;
    if (r) begin act = 0; m = 0; cnt = 0; ph = 0; end
    else if (fl) act = 0;
    else if (!act) begin if (hs) begin act = 1; ph = 1; m = dec; end end
    else if (ph < NR + 2) ph++;
    else if (ordy) begin
      cnt = cnt + 16'd1;
      if (hs) begin ph = 1; m = dec; end else act = 0;
    end
  endtask

  initial begin
    repeat (2) step("reset", 1, 0, 0, 1, 1, 1);
    step("idle", 0, 0, 0, 0, 0, 0);
    step("enc_accept", 0, 0, 0, 1, 0, 0);
    repeat (NR + 4) step("enc_run", 0, 0, 0, 0, 0, 0);
    step("enc_drain", 0, 0, 0, 0, 0, 1);
    step("dec_accept", 0, 0, 0, 1, 1, 0);
    repeat (NR + 3) step("dec_run", 0, 0, 0, 0, 0, 0);
    step("dec_drain", 0, 0, 0, 0, 0, 1);
    repeat (3 * (NR + 2) + 1) step("b2b", 0, 0, 0, 1, 1'($urandom), 1);
    repeat (NR + 2) step("b2b_hold", 0, 0, 0, 1, 0, 0);
    repeat (5) step("stall", 0, 0, 0, 1, 1, 0);
    step("stall_drain", 0, 0, 0, 0, 0, 1);
    step("idle2", 0, 0, 0, 0, 0, 0);
    repeat (3) step("keybusy", 0, 0, 1, 1, 1, 0);
    step("key_release", 0, 0, 0, 1, 1, 0);
    while (ph < 6) step("to_round5", 0, 0, 0, 0, 0, 0);
    step("flush_round5", 0, 1, 0, 1, 0, 1);
    repeat (2) step("post_flush", 0, 0, 0, 0, 0, 0);
    step("flush_hs", 0, 1, 0, 1, 0, 0);
    step("post_flush_hs", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++)
      step("random", 0, $urandom_range(0, 39) == 0, act ? 1'b0 : $urandom_range(0, 3) == 0,
           1'($urandom), 1'($urandom), 1'($urandom));
    while (act) step("settle", 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    force dut.cnt_q = 16'hFFFF;
    #1 release dut.cnt_q;
    cnt = 16'hFFFF;
    step("wrap_accept", 0, 0, 0, 1, 0, 0);
    repeat (NR + 1) step("wrap_run", 0, 0, 0, 0, 0, 0);
    step("wrap_done", 0, 0, 0, 0, 0, 1);
    step("wrap_zero", 0, 0, 0, 1, 1, 0);
    repeat (NR + 3) step("rst_run", 0, 0, 0, 0, 0, 0);
    step("rst_in_done", 1, 0, 0, 1, 0, 1);
    step("after_rst", 0, 0, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
